two_of_five_serializer: RTL and testbench

- Accepts a word of `NDIGITS` packed BCD digits through a valid/ready handshake.
- Emits the word one digit per beat, least-significant digit first, as 2-of-5 codewords on a second valid/ready stream.
- Non-decimal nibbles are flagged on the beat where they are emitted.
- Sits between the BCD arithmetic/display datapath and the serial 2-of-5 line driver. It is the registered, multi-digit, flow-controlled successor of the single-digit combinational encoder.

---
 rtl/two_of_five_serializer.sv | 135 +++++++++++++
 tb/tb_two_of_five_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/two_of_five_serializer.sv
// Registered BCD-to-2-of-5 serializer: one packed word in, one codeword per digit out, LSD first.
// Optional saturating error-beat counter on err_count when TWO5_ERR_CNT_EN is defined.
module two_of_five_serializer #(
    parameter int NDIGITS = 4,
    parameter int ERR_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   in_bcd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_code,
    output logic                   out_last,
    output logic                   out_err
`ifdef TWO5_ERR_CNT_EN
    ,
    output logic [ERR_W-1:0]       err_count
`endif
);

    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

    generate
        if (NDIGITS < 1 || NDIGITS > 16 || ERR_W < 1) begin : g_bad_param
            $error("two_of_five_serializer: illegal NDIGITS or ERR_W");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state_q, state_d;
    logic [4*NDIGITS-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     idx_inc;
    logic [3:0]           next_nib;
    logic                 out_valid_d, out_last_d, out_err_d;
    logic [4:0]           out_code_d;
    logic                 beat_fire, last_fire, accept;

    // Returns {err, code}; non-decimal nibbles map to an all-zero code.
    function automatic logic [5:0] encode(input logic [3:0] nib);
        case (nib)
            4'd0:    encode = 6'b0_00011;
            4'd1:    encode = 6'b0_00101;
            4'd2:    encode = 6'b0_00110;
            4'd3:    encode = 6'b0_01001;
            4'd4:    encode = 6'b0_01010;
            4'd5:    encode = 6'b0_01100;
            4'd6:    encode = 6'b0_10001;
            4'd7:    encode = 6'b0_10010;
            4'd8:    encode = 6'b0_10100;
            4'd9:    encode = 6'b0_11000;
            default: encode = 6'b1_00000;
        endcase
    endfunction

    assign beat_fire = out_valid && out_ready;
    assign last_fire = beat_fire && out_last;
    assign in_ready  = rst_n && ((state_q == IDLE) || last_fire);
    assign accept    = in_valid && in_ready;
    assign idx_inc   = idx_q + 1'b1;
    assign next_nib  = 4'(hold_q >> {idx_inc, 2'b00});

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        out_valid_d = out_valid;
        out_code_d  = out_code;
        out_last_d  = out_last;
        out_err_d   = out_err;

        case (state_q)
            IDLE: ;
            SEND: begin
                if (last_fire) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else if (beat_fire) begin
                    idx_d                   = idx_inc;
                    {out_err_d, out_code_d} = encode(next_nib);
                    out_last_d              = (idx_inc == IDX_LAST);
                end
            end
            default: state_d = IDLE;
        endcase

        // A new word overrides the return to IDLE so back-to-back words have no bubble.
        if (accept) begin
            state_d                 = SEND;
            hold_d                  = in_bcd;
            idx_d                   = '0;
            out_valid_d             = 1'b1;
            {out_err_d, out_code_d} = encode(in_bcd[3:0]);
            out_last_d              = (IDX_LAST == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            out_valid <= out_valid_d;
            out_code  <= out_code_d;
            out_last  <= out_last_d;
            out_err   <= out_err_d;
        end
    end

`ifdef TWO5_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (beat_fire && out_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_two_of_five_serializer.sv
// Self-checking bench for two_of_five_serializer: queue-based beat model plus directed literal checks,
// followed by a randomized traffic phase with random backpressure and a mid-run reset.
module tb_two_of_five_serializer;

    localparam int NDIGITS = 4;
`ifdef TWO5_ERR_CNT_EN
    localparam int ERR_W = 2;
`else
    localparam int ERR_W = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_code;
    logic        out_last;
    logic        out_err;
`ifdef TWO5_ERR_CNT_EN
    logic [ERR_W-1:0] err_count;
`endif

    always #5 clk = ~clk;

    two_of_five_serializer #(.NDIGITS(NDIGITS), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_err   (out_err)
`ifdef TWO5_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    typedef struct {
        logic [4:0] code;
        logic       last;
        logic       err;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    err_model = 0;
    bit    started = 0;
    beat_t exp_q[$];
    beat_t popped;
    int    got_code[$];
    int    got_last[$];
    int    got_err[$];
    int    got_cyc[$];
    int    acc_cyc[$];

    function automatic logic [4:0] model_code(input logic [3:0] d);
        logic [4:0] tbl [10];
        tbl = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
                5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
        if (d > 4'd9) return 5'b00000;
        return tbl[int'(d)];
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: every accepted word becomes NDIGITS expected beats; every handshaken beat retires one.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            err_model = 0;
            started   = 1;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    if (popped.err && err_model < (1 << ERR_W) - 1) err_model++;
                end
                got_code.push_back(int'(out_code));
                got_last.push_back(int'(out_last));
                got_err.push_back(int'(out_err));
                got_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < NDIGITS; k++) begin
                    beat_t b;
                    b.code = model_code(in_bcd[4*k +: 4]);
                    b.err  = (in_bcd[4*k +: 4] > 4'd9);
                    b.last = (k == NDIGITS - 1);
                    exp_q.push_back(b);
                end
                acc_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit exp_ready;
            exp_ready = rst_n && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready));
            check("in_ready", int'(in_ready), int'(exp_ready));
            check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            if (out_valid && exp_q.size() > 0) begin
                check("out_code", int'(out_code), int'(exp_q[0].code));
                check("out_last", int'(out_last), int'(exp_q[0].last));
                check("out_err", int'(out_err), int'(exp_q[0].err));
            end
`ifdef TWO5_ERR_CNT_EN
            check("err_count", int'(err_count), err_model);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_code.delete();
        got_last.delete();
        got_err.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    task automatic send_word(input logic [15:0] w, input bit keep_valid);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        in_bcd   = w;
        for (int n = 0; n < 200 && !acc; n++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("accept_timeout", 0, 1);
        if (!keep_valid) begin
            in_valid = 1'b0;
            in_bcd   = 16'($urandom);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (!out_valid) break;
            tick();
        end
        check("drain_timeout", int'(out_valid), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_code", int'(out_code), 0);
        check("reset_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        tick();

        // Basic word
        clear_logs();
        send_word(16'h1234, 0);
        drain();
        check("basic_beats", got_code.size(), 4);
        if (got_code.size() == 4) begin
            check("basic_b0", got_code[0], 5'b01010);
            check("basic_b1", got_code[1], 5'b01001);
            check("basic_b2", got_code[2], 5'b00110);
            check("basic_b3", got_code[3], 5'b00101);
            check("basic_last", got_last[0] + got_last[1] + got_last[2], 0);
            check("basic_last3", got_last[3], 1);
            check("basic_err", got_err[0] + got_err[1] + got_err[2] + got_err[3], 0);
            check("basic_latency", got_cyc[0] - acc_cyc[0], 1);
            check("basic_thruput", got_cyc[3] - got_cyc[0], 3);
        end

        // Invalid digits
        clear_logs();
        send_word(16'h9AF0, 0);
        drain();
        check("inv_beats", got_code.size(), 4);
        if (got_code.size() == 4) begin
            check("inv_b0", got_code[0], 5'b00011);
            check("inv_b1", got_code[1], 5'b00000);
            check("inv_b2", got_code[2], 5'b00000);
            check("inv_b3", got_code[3], 5'b11000);
            check("inv_err", got_err[0] * 8 + got_err[1] * 4 + got_err[2] * 2 + got_err[3], 6);
        end
`ifdef TWO5_ERR_CNT_EN
        check("inv_err_count", int'(err_count), 2);
`endif

        // Backpressure on beat 2
        clear_logs();
        send_word(16'h5678, 0);
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_code", int'(out_code), 5'b10001);
            check("stall_valid", int'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        drain();
        check("bp_beats", got_code.size(), 4);
        if (got_code.size() == 4) begin
            check("bp_b0", got_code[0], 5'b10100);
            check("bp_b1", got_code[1], 5'b10010);
            check("bp_b2", got_code[2], 5'b10001);
            check("bp_b3", got_code[3], 5'b01100);
        end

        // Back-to-back words
        clear_logs();
        send_word(16'h0000, 1);
        send_word(16'h9999, 0);
        drain();
        check("b2b_beats", got_code.size(), 8);
        if (got_code.size() == 8 && acc_cyc.size() == 2) begin
            for (int i = 0; i < 8; i++)
                check("b2b_code", got_code[i], (i < 4) ? 5'b00011 : 5'b11000);
            check("b2b_consecutive", got_cyc[7] - got_cyc[0], 7);
            check("b2b_accept_on_last", acc_cyc[1], got_cyc[3]);
        end

        // Reset mid-word
        clear_logs();
        send_word(16'h1234, 0);
        tick();
        rst_n = 1'b0;
        tick();
        check("rst_out_valid", int'(out_valid), 0);
`ifdef TWO5_ERR_CNT_EN
        check("rst_err_count", int'(err_count), 0);
`endif
        rst_n = 1'b1;
        tick();
        check("rst_no_partial", int'(out_valid), 0);
        clear_logs();
        send_word(16'h0007, 0);
        drain();
        check("rst_new_beats", got_code.size(), 4);
        if (got_code.size() > 0) check("rst_new_first", got_code[0], 5'b10010);

`ifdef TWO5_ERR_CNT_EN
        // Saturation
        for (int w = 0; w < 5; w++) send_word(16'hFFFF, 0);
        drain();
        check("sat_err_count", int'(err_count), 3);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] w;
            for (int k = 0; k < 4; k++)
                w[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9));
            in_valid  = ($urandom_range(0, 2) != 0);
            in_bcd    = w;
            out_ready = ($urandom_range(0, 3) != 0);
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
